// File: rtl/hiscore_pkg.sv
// hiscore_pkg
// Shared constants and address helpers for the high-score bridge leaf.
//   HS_BASE_ADDR  byte address of table word 0
//   HS_NUM_WORDS  table depth in 32-bit words
//   HS_IDX_W      word index width
//   hs_in_range() 1 when a byte address falls inside the table window
//   hs_idx()      full-width word offset of a byte address from the base
package hiscore_pkg;

    localparam logic [31:0] HS_BASE_ADDR = 32'h1000_1620;
    localparam int unsigned HS_NUM_WORDS = 20;
    localparam int          HS_IDX_W     = $clog2(HS_NUM_WORDS);

    // The offset is computed first so an address below the base wraps to a
    // huge value; the explicit lower-bound test keeps that case out as well.
    function automatic logic hs_in_range(
        input logic [31:0] addr,
        input logic [31:0] base      = HS_BASE_ADDR,
        input int unsigned num_words = HS_NUM_WORDS
    );
        logic [31:0] off;
        off = addr - base;
        return (addr >= base) && (off < (num_words * 4));
    endfunction

    // Byte lanes [1:0] are dropped; the result is left 32 bits wide so the
    // caller can compare it against the last index without truncation.
    function automatic logic [31:0] hs_idx(
        input logic [31:0] addr,
        input logic [31:0] base = HS_BASE_ADDR
    );
        return (addr - base) >> 2;
    endfunction

endpackage

// File: rtl/hiscore_ram.sv
// hiscore_ram
// Single-port DEPTH x 32 table with a one-cycle registered read.
// A write returns the previous contents of the addressed word on o_rdata.
//   clk      clock
//   i_en     port enable (read and/or write this cycle)
//   i_we     write enable, qualified by i_en
//   i_addr   word index
//   i_wdata  write data
//   o_rdata  registered read data, valid the cycle after i_en
module hiscore_ram
    import hiscore_pkg::*;
#(
    parameter int unsigned DEPTH = HS_NUM_WORDS,
    parameter int          AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    // No reset on the array or the read register so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/hiscore_leaf.sv
// hiscore_leaf
// Bridge leaf for the high-score table, shared with the game core.
//   clk, reset        bridge clock, synchronous active-high reset
//   bridge_addr/wr/wr_data/rd/rd_data
//                     host side; reads return data two cycles after the strobe
//   core_req/we/idx/wdata/ready/rvalid/rdata
//                     core side; request held until core_ready, read data one
//                     cycle after acceptance
//   loaded            host has written the last word since reset
//   dirty             core modified the table since the last full host readback
module hiscore_leaf
    import hiscore_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = HS_BASE_ADDR,
    parameter int unsigned NUM_WORDS = HS_NUM_WORDS,
    parameter int          IDX_W     = $clog2(NUM_WORDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      bridge_addr,
    input  logic             bridge_wr,
    input  logic [31:0]      bridge_wr_data,
    input  logic             bridge_rd,
    output logic [31:0]      bridge_rd_data,
    input  logic             core_req,
    input  logic             core_we,
    input  logic [IDX_W-1:0] core_idx,
    input  logic [31:0]      core_wdata,
    output logic             core_ready,
    output logic             core_rvalid,
    output logic [31:0]      core_rdata,
    output logic             loaded,
    output logic             dirty
);

    // ---------------- address decode ----------------
    logic        w_in_range;
    logic [31:0] w_word;
    logic        w_is_last;

    assign w_in_range = hs_in_range(bridge_addr, BASE_ADDR, NUM_WORDS);
    assign w_word     = hs_idx(bridge_addr, BASE_ADDR);
    assign w_is_last  = w_in_range && (w_word == 32'(NUM_WORDS - 1));

    // ---------------- arbitration ----------------
    // Write wins if both strobes arrive together. An out-of-range read still
    // enters the pipeline (to return zero on time) but leaves the RAM free.
    logic w_br_wr;
    logic w_br_rd_any;
    logic w_br_own;
    logic w_core_grant;
    logic w_core_wr;

    assign w_br_wr      = bridge_wr && w_in_range;
    assign w_br_rd_any  = bridge_rd && !bridge_wr;
    assign w_br_own     = w_br_wr || (w_br_rd_any && w_in_range);
    assign w_core_grant = core_req && !w_br_own && !reset;
    assign w_core_wr    = w_core_grant && core_we;

    // ---------------- RAM ----------------
    logic             w_ram_en;
    logic             w_ram_we;
    logic [IDX_W-1:0] w_ram_addr;
    logic [31:0]      w_ram_wdata;
    logic [31:0]      w_ram_rdata;

    assign w_ram_en    = w_br_own || w_core_grant;
    assign w_ram_we    = w_br_wr || w_core_wr;
    assign w_ram_addr  = w_br_own ? w_word[IDX_W-1:0] : core_idx;
    assign w_ram_wdata = w_br_wr ? bridge_wr_data : core_wdata;

    hiscore_ram #(
        .DEPTH (NUM_WORDS),
        .AW    (IDX_W)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    // ---------------- read pipeline and flags ----------------
    // Stage 1 tracks a bridge read whose RAM data appears the next cycle;
    // r_bridge_rd_data is the second stage and holds until the next read.
    logic        r_s1_valid;
    logic        r_s1_hit;
    logic        r_s1_last;
    logic [31:0] r_bridge_rd_data;
    logic        r_core_rvalid;
    logic        r_loaded;
    logic        r_dirty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid       <= 1'b0;
            r_s1_hit         <= 1'b0;
            r_s1_last        <= 1'b0;
            r_bridge_rd_data <= '0;
            r_core_rvalid    <= 1'b0;
            r_loaded         <= 1'b0;
            r_dirty          <= 1'b0;
        end else begin
            r_s1_valid    <= w_br_rd_any;
            r_s1_hit      <= w_in_range;
            r_s1_last     <= w_is_last;
            r_core_rvalid <= w_core_grant && !core_we;

            if (r_s1_valid) begin
                r_bridge_rd_data <= r_s1_hit ? w_ram_rdata : 32'h0;
            end

            if (w_br_wr && w_is_last) begin
                r_loaded <= 1'b1;
            end

            // A core write in the same cycle as the final readback keeps the
            // table marked modified: that write was not part of the save.
            if (w_core_wr && r_loaded) begin
                r_dirty <= 1'b1;
            end else if (r_s1_valid && r_s1_last) begin
                r_dirty <= 1'b0;
            end
        end
    end

    assign bridge_rd_data = r_bridge_rd_data;
    assign core_ready     = w_core_grant;
    assign core_rvalid    = r_core_rvalid;
    assign core_rdata     = r_core_rvalid ? w_ram_rdata : 32'h0;
    assign loaded         = r_loaded;
    assign dirty          = r_dirty;

endmodule
